// File: rtl/wb_pkg.sv
// Shared constants and result type for the writeback arbiter and its per-source buffers.
package wb_pkg;
    localparam int SRC_ALU         = 0;
    localparam int SRC_LSU         = 1;
    localparam int SRC_MULDIV      = 2;
    localparam int NUM_SRC_DEFAULT = 3;
    localparam int RN_W_DEFAULT    = 6;
    localparam int DATA_W_DEFAULT  = 64;

    localparam logic [5:0] RN_ZERO = 6'h0;

    typedef struct packed {
        logic [RN_W_DEFAULT-1:0]   rn;
        logic [DATA_W_DEFAULT-1:0] data;
    } wb_result_t;
endpackage

// File: rtl/wb_slot_fifo.sv
// Two-entry result buffer for one execution unit; ready is registered from next-state occupancy.
module wb_slot_fifo
    import wb_pkg::*;
#(
    parameter int RN_W   = RN_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [RN_W-1:0]   push_rn,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [RN_W-1:0]   head_rn,
    output logic [DATA_W-1:0] head_data,
    output logic              nonempty,
    output logic              ready
);
    logic [RN_W-1:0]   rn_q   [2];
    logic [DATA_W-1:0] data_q [2];
    logic              wr_q, rd_q, ready_q;
    logic [1:0]        cnt_q, cnt_d;

    // The producer never pushes at count 2 and the arbiter never pops when empty.
    always_comb cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d < 2'd2);
            if (push) wr_q <= ~wr_q;
            if (pop)  rd_q <= ~rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rn_q[wr_q]   <= push_rn;
            data_q[wr_q] <= push_data;
        end
    end

    assign head_rn   = rn_q[rd_q];
    assign head_data = data_q[rd_q];
    assign nonempty  = (cnt_q != 2'd0);
    assign ready     = ready_q;
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result buffers, round-robin pick, registered register-file write port.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int RN_W    = RN_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*RN_W-1:0]   src_rn,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      w_en,
    output logic [RN_W-1:0]           w_rn,
    output logic [DATA_W-1:0]         w_data,
    output logic                      busy
);
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] nonempty, pop;
    logic [RN_W-1:0]    head_rn   [NUM_SRC];
    logic [DATA_W-1:0]  head_data [NUM_SRC];
    logic [PW-1:0]      ptr_q, ptr_d, gnt;
    logic               found;
    logic               w_en_q;
    logic [RN_W-1:0]    w_rn_q;
    logic [DATA_W-1:0]  w_data_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [RN_W-1:0] rn_i;
        logic            push_i;
        assign rn_i = src_rn[i*RN_W +: RN_W];
        // Writes to r0 complete the handshake but are dropped before buffering.
        assign push_i = src_valid[i] & src_ready[i] & (rn_i != RN_W'(RN_ZERO));

        wb_slot_fifo #(.RN_W(RN_W), .DATA_W(DATA_W)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_i),
            .push_rn   (rn_i),
            .push_data (src_data[i*DATA_W +: DATA_W]),
            .pop       (pop[i]),
            .head_rn   (head_rn[i]),
            .head_data (head_data[i]),
            .nonempty  (nonempty[i]),
            .ready     (src_ready[i])
        );
    end

    always_comb begin : p_arb
        int idx;
        idx   = 0;
        gnt   = '0;
        found = 1'b0;
        pop   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                gnt   = PW'(idx);
            end
        end
        if (found) pop[gnt] = 1'b1;
        ptr_d = ptr_q;
        if (found) ptr_d = (gnt == PW'(NUM_SRC - 1)) ? '0 : gnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            w_en_q   <= 1'b0;
            w_rn_q   <= '0;
            w_data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            w_en_q <= found;
            if (found) begin
                w_rn_q   <= head_rn[gnt];
                w_data_q <= head_data[gnt];
            end
        end
    end

    assign w_en   = w_en_q;
    assign w_rn   = w_rn_q;
    assign w_data = w_data_q;
    assign busy   = (|nonempty) | w_en_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: per-source expected queues filled at acceptance, drained on writes.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int NS = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NS-1:0]  src_valid = '0;
    logic [NS-1:0]  src_ready;
    logic [NS*6-1:0]  src_rn = '0;
    logic [NS*64-1:0] src_data = '0;
    logic           w_en;
    logic [5:0]     w_rn;
    logic [63:0]    w_data;
    logic           busy;

    wb_result_t pend  [NS][$];
    wb_result_t exp_q [NS][$];
    int wlog[$];
    int wcyc[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int wait_c [NS];
    int max_wait = 0;
    logic lsu_stall_seen = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter #(.NUM_SRC(NS), .DATA_W(64), .RN_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_rn    (src_rn),
        .src_data  (src_data),
        .w_en      (w_en),
        .w_rn      (w_rn),
        .w_data    (w_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (pend[i].size() > 0) begin
                src_valid[i]       = 1'b1;
                src_rn[i*6 +: 6]   = pend[i][0].rn;
                src_data[i*64 +: 64] = pend[i][0].data;
            end else begin
                src_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic add(input int s, input int rn, input logic [59:0] payload);
        wb_result_t r;
        r.rn   = 6'(rn);
        r.data = {4'(s), payload};
        pend[s].push_back(r);
    endtask

    // One clock: account transfers, check any write against the scoreboard, redrive inputs.
    task automatic step();
        logic [NS-1:0] xfer;
        logic [NS-1:0] wrote;
        xfer  = rst ? '0 : (src_valid & src_ready);
        wrote = '0;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NS; i++) begin
            if (xfer[i]) begin
                wb_result_t r;
                r = pend[i].pop_front();
                if (r.rn != 6'd0) exp_q[i].push_back(r);
            end
        end
        if (w_en) begin
            int s;
            s = int'(w_data[63:60]);
            if (s < NS && exp_q[s].size() > 0) begin
                wb_result_t e;
                e = exp_q[s].pop_front();
                chk("w_rn", 64'(w_rn), 64'(e.rn));
                chk("w_data", w_data, e.data);
                wrote[s] = 1'b1;
            end else begin
                chk("unexpected_write", 64'(w_en), 64'(0));
            end
            wlog.push_back(int'(w_rn));
            wcyc.push_back(cyc);
        end
        for (int i = 0; i < NS; i++) begin
            if (wrote[i] || exp_q[i].size() == 0) wait_c[i] = 0;
            else begin
                wait_c[i]++;
                if (wait_c[i] > max_wait) max_wait = wait_c[i];
            end
        end
        if (!src_ready[SRC_LSU]) lsu_stall_seen = 1'b1;
        drive();
    endtask

    function automatic int outstanding();
        int n;
        n = 0;
        for (int i = 0; i < NS; i++) n += pend[i].size() + exp_q[i].size();
        return n;
    endfunction

    task automatic drain(input int lim);
        int k;
        k = 0;
        while ((busy || outstanding() > 0) && k < lim) begin
            step();
            k++;
        end
        chk("drain_bound", 64'(busy || outstanding() > 0), 64'(0));
    endtask

    initial begin
        // Reset with all sources asserting valid.
        src_valid = 3'b111;
        src_rn    = {6'd3, 6'd2, 6'd1};
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk("rst_ready", 64'(src_ready), 64'(3'b111));
            chk("rst_w_en", 64'(w_en), 64'(0));
            chk("rst_w_rn", 64'(w_rn), 64'(0));
            chk("rst_w_data", w_data, 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
        end
        src_valid = '0;
        rst = 1'b0;
        step();

        // Round robin: two simultaneous bursts, writes in source order each time.
        wlog.delete();
        wcyc.delete();
        add(SRC_ALU, 1, 60'h11);
        add(SRC_LSU, 2, 60'h12);
        add(SRC_MULDIV, 3, 60'h13);
        drive();
        drain(20);
        add(SRC_ALU, 4, 60'h21);
        add(SRC_LSU, 5, 60'h22);
        add(SRC_MULDIV, 6, 60'h23);
        drive();
        drain(20);
        chk("rr_count", 64'(wlog.size()), 64'(6));
        if (wlog.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("rr_order", 64'(wlog[i]), 64'(i + 1));
            chk("rr_back2back_a", 64'(wcyc[1] - wcyc[0]), 64'(1));
            chk("rr_back2back_b", 64'(wcyc[2] - wcyc[1]), 64'(1));
        end

        // Single write latency: transfer edge N, write visible after edge N+1.
        add(SRC_ALU, 5, 60'hDEAD_BEEF);
        drive();
        step();
        chk("single_n_w_en", 64'(w_en), 64'(0));
        chk("single_n_busy", 64'(busy), 64'(1));
        step();
        chk("single_n1_w_en", 64'(w_en), 64'(1));
        chk("single_n1_w_rn", 64'(w_rn), 64'(5));
        chk("single_n1_w_data", w_data, 64'hDEAD_BEEF);
        chk("single_n1_busy", 64'(busy), 64'(1));
        step();
        chk("single_n2_w_en", 64'(w_en), 64'(0));
        chk("single_n2_busy", 64'(busy), 64'(0));
        chk("single_n2_w_rn_hold", 64'(w_rn), 64'(5));

        // Backpressure: LSU burst of 4 against continuous ALU and MULDIV streams.
        for (int i = 0; i < NS; i++) wait_c[i] = 0;
        max_wait = 0;
        lsu_stall_seen = 1'b0;
        for (int k = 0; k < 4; k++) add(SRC_LSU, 10 + k, 60'(k));
        for (int k = 0; k < 6; k++) begin
            add(SRC_ALU, 20 + k, 60'(k));
            add(SRC_MULDIV, 30 + k, 60'(k));
        end
        drive();
        drain(100);
        chk("bp_lsu_stalled", 64'(lsu_stall_seen), 64'(1));
        chk("bp_fairness", 64'(max_wait <= 3), 64'(1));

        // Register 0 result: accepted, never buffered, never written.
        add(SRC_MULDIV, 0, 60'h1234);
        drive();
        for (int c = 0; c < 4; c++) begin
            step();
            chk("r0_ready", 64'(src_ready[SRC_MULDIV]), 64'(1));
            chk("r0_w_en", 64'(w_en), 64'(0));
            chk("r0_busy", 64'(busy), 64'(0));
        end
        chk("r0_consumed", 64'(pend[SRC_MULDIV].size()), 64'(0));

        // Reset mid-flight discards everything buffered.
        add(SRC_ALU, 40, 60'h40);
        add(SRC_ALU, 41, 60'h41);
        add(SRC_LSU, 50, 60'h50);
        add(SRC_LSU, 51, 60'h51);
        drive();
        step();
        step();
        chk("mf_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        for (int i = 0; i < NS; i++) pend[i].delete();
        drive();
        step();
        for (int i = 0; i < NS; i++) exp_q[i].delete();
        chk("mf_w_en", 64'(w_en), 64'(0));
        chk("mf_ready", 64'(src_ready), 64'(3'b111));
        chk("mf_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("mf_no_write", 64'(w_en), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
